alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Parametrised, handshaked sequential ALU; next generation of the tt_um_alu_8bits datapath.
- Generalised to WIDTH bits, with registered flags and valid/ready on both sides.
- Adds multi-cycle shift-add multiply and restoring divide.
- Sits behind the top-level pin wrapper, which maps ui_in/uio_in onto operands and uo_out onto results.

Parameters:
- WIDTH, 8: operand width in bits; must be at least 4. SHW = clog2(WIDTH), derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  core can accept a request.
- op  in  4  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- res_lo  out  WIDTH  primary result; quotient for DIV.
- res_hi  out  WIDTH  upper product for MUL; remainder for DIV; 0 for all other ops.
- flags  out  5  {e,v,c,n,z}: error, signed overflow, carry/borrow, negative, zero.
- busy  out  1  high while in BUSY.

Behaviour:
- One clock domain. Reset is synchronous and active-high (rst sampled on clk rising edge).
- Reset values: state=IDLE, in_ready=1, out_valid=0, res_lo=0, res_hi=0, flags=0, busy=0, iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). Accept when in_valid && in_ready; a, b and op are captured at that edge.
- IDLE -> DONE when a single-cycle op is accepted. out_valid rises the cycle after the accept edge (latency 1).
- IDLE -> BUSY when MUL or DIV is accepted with b!=0. BUSY runs WIDTH iterations with the counter going 0..WIDTH-1, then -> DONE. out_valid rises exactly WIDTH+1 cycles after the accept edge.
- DONE: res_lo, res_hi, flags and out_valid are held stable until out_valid && out_ready. That edge -> IDLE and clears out_valid. No new request is accepted in the same cycle; throughput is at most one op per 2 cycles.
- Opcodes:
  - 0 ADD: WIDTH+1-bit sum. c = carry out. v = signed overflow.
  - 1 SUB: a-b. c = borrow (a<b unsigned). v = signed overflow.
  - 2 AND, 3 OR, 4 XOR, 5 NOT (~a): c=v=0.
  - 6 SHL, 7 SHR (logical), 8 SAR: shift amount is b[SHW-1:0]. c = last bit shifted out; c=0 when amount is 0. v=0.
  - 9 MUL: unsigned, {res_hi,res_lo} = a*b. c = v = (res_hi!=0).
  - 10 DIV: unsigned, res_lo = a/b, res_hi = a%b. c = v = 0.
  - 11-15: illegal. res_lo=res_hi=0, e=1, single-cycle.
- z = (res_lo==0). n = res_lo[WIDTH-1]. e = 0 unless stated otherwise.
- DIV with b==0: single-cycle path (no BUSY). res_lo = all ones, res_hi = a, e=1, z=0, n=1.
- MUL with b==0 runs the full WIDTH iterations (no early exit).
- rst asserted in any state, including mid-BUSY: aborts the operation and applies the reset values the next cycle; no partial result is ever presented.
- in_valid while not ready is ignored; the requester must hold it.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: DIV is implemented as specified above.
- Undefined: no divider hardware. Opcode 10 is treated as illegal: single-cycle, res_lo=res_hi=0, e=1. MUL is unaffected.

Test Plan (WIDTH=8):
- ADD a=0xFF b=0x01 -> one cycle after accept: res_lo=0x00, res_hi=0x00, z=1, c=1, v=0, n=0, e=0.
- SUB a=0x80 b=0x01 -> res_lo=0x7F, v=1, c=0, n=0. Then SAR a=0x90 b=0x02 -> res_lo=0xE4, c=0, n=1.
- MUL a=0xFF b=0xFF -> busy=1 for 8 cycles; out_valid rises 9 cycles after accept; res_hi=0xFE, res_lo=0x01, c=v=1; in_ready=0 throughout.
- DIV a=200 b=7 -> after 9 cycles: res_lo=0x1C, res_hi=0x04, e=0.
- DIV a=0x55 b=0x00 -> after 1 cycle: res_lo=0xFF, res_hi=0x55, e=1.
- With the macro undefined, DIV a=200 b=7 -> after 1 cycle: res_lo=res_hi=0, e=1.
- Backpressure and reset:
  - out_ready=0 for 5 cycles after a result -> outputs stable, in_ready=0; handshake on cycle 6 -> IDLE.
  - rst asserted 3 cycles into a MUL -> next cycle all outputs at reset values, in_ready=1; a fresh ADD 0x01+0x02 then gives res_lo=0x03.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq_core.
// master = requester/consumer side, slave = the ALU core.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic [4:0]       flags;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, flags, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res_lo, res_hi, flags, busy
    );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked WIDTH-bit ALU with registered flags {e,v,c,n,z}, shift-add MUL and restoring DIV.
// Define ALU_SEQ_DIV_EN to build the divider; without it opcode 10 decodes as illegal.
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    // state | meaning
    // IDLE  | ready to accept a request
    // BUSY  | iterating MUL/DIV, counter runs 0..WIDTH-1
    // DONE  | result presented and held until out_ready
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int              SHW      = $clog2(WIDTH);
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                           OP_SAR = 4'd8, OP_MUL = 4'd9, OP_DIV = 4'd10;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opd, work_hi, work_lo;

    logic             start_multi;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext, sar_ext;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_e, sc_v, sc_c;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             mul_ovf;

    function automatic logic [4:0] mk_flags(input logic e, input logic v, input logic c,
                                            input logic [WIDTH-1:0] lo);
        return {e, v, c, lo[WIDTH-1], lo == '0};
    endfunction

    always_comb begin
        start_multi = (bus.op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
        if (bus.op == OP_DIV && bus.b != '0) start_multi = 1'b1;
`endif
    end

    // Shifts use one guard bit so the last bit shifted out lands in a fixed position.
    always_comb begin
        amt     = bus.b[SHW-1:0];
        add_ext = {1'b0, bus.a} + {1'b0, bus.b};
        sub_ext = {1'b0, bus.a} - {1'b0, bus.b};
        shl_ext = {1'b0, bus.a} << amt;
        shr_ext = {bus.a, 1'b0} >> amt;
        sar_ext = $signed({bus.a, 1'b0}) >>> amt;
        sc_lo   = '0;
        sc_hi   = '0;
        sc_e    = 1'b0;
        sc_v    = 1'b0;
        sc_c    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sc_lo = add_ext[WIDTH-1:0];
                sc_c  = add_ext[WIDTH];
                sc_v  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo = sub_ext[WIDTH-1:0];
                sc_c  = sub_ext[WIDTH];
                sc_v  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: sc_lo = bus.a & bus.b;
            OP_OR:  sc_lo = bus.a | bus.b;
            OP_XOR: sc_lo = bus.a ^ bus.b;
            OP_NOT: sc_lo = ~bus.a;
            OP_SHL: begin
                sc_lo = shl_ext[WIDTH-1:0];
                sc_c  = shl_ext[WIDTH];
            end
            OP_SHR: begin
                sc_lo = shr_ext[WIDTH:1];
                sc_c  = shr_ext[0];
            end
            OP_SAR: begin
                sc_lo = sar_ext[WIDTH:1];
                sc_c  = sar_ext[0];
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                sc_lo = '1;
                sc_hi = bus.a;
                sc_e  = 1'b1;
            end
`endif
            default: sc_e = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0] div_shift, div_trial;
`endif

    // work_hi/work_lo hold partial product (MUL) or remainder/quotient (DIV).
    always_comb begin
        mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opd} : '0);
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opd};
        if (op_q == OP_DIV) begin
            step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], ~div_trial[WIDTH]};
        end
`endif
        mul_ovf = (op_q == OP_MUL) && (step_hi != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_q          <= '0;
            opd           <= '0;
            work_hi       <= '0;
            work_lo       <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.res_lo    <= '0;
            bus.res_hi    <= '0;
            bus.flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q         <= bus.op;
                        opd          <= (bus.op == OP_MUL) ? bus.a : bus.b;
                        work_lo      <= (bus.op == OP_MUL) ? bus.b : bus.a;
                        work_hi      <= '0;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        if (start_multi) begin
                            state    <= BUSY;
                            bus.busy <= 1'b1;
                        end else begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.res_lo    <= sc_lo;
                            bus.res_hi    <= sc_hi;
                            bus.flags     <= mk_flags(sc_e, sc_v, sc_c, sc_lo);
                        end
                    end
                end
                BUSY: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        cnt           <= '0;
                        bus.busy      <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.res_lo    <= step_lo;
                        bus.res_hi    <= step_hi;
                        bus.flags     <= mk_flags(1'b0, mul_ovf, mul_ovf, step_lo);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed-vector bench for alu_seq_core (WIDTH=8); DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq_core;
    localparam int W = 8;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
                           OP_SAR = 4'd8, OP_MUL = 4'd9, OP_DIV = 4'd10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq_core #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int exp_lat, input logic [7:0] exp_lo,
                          input logic [7:0] exp_hi, input logic [4:0] exp_flags);
        int lat, n_busy, n_rdy;
        @(negedge clk);
        chk({tag, "_idle"}, bus.in_ready, 1);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0; n_busy = 0; n_rdy = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.in_ready) n_rdy++;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            if (bus.busy) n_busy++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, n_busy, exp_lat - 1);
        chk({tag, "_rdy"}, n_rdy, 0);
        chk({tag, "_lo"}, bus.res_lo, exp_lo);
        chk({tag, "_hi"}, bus.res_hi, exp_hi);
        chk({tag, "_flags"}, bus.flags, exp_flags);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({tag, "_drain"}, {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_bad;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res", {bus.res_hi, bus.res_lo}, 16'h0000);
        chk("rst_flags", bus.flags, 5'b00000);

        //              tag          op      a      b      lat lo     hi     {e,v,c,n,z}
        run_op("add_ff_01",  OP_ADD, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 5'b00101);
        run_op("sub_80_01",  OP_SUB, 8'h80, 8'h01, 1, 8'h7F, 8'h00, 5'b01000);
        run_op("sar_90_02",  OP_SAR, 8'h90, 8'h02, 1, 8'hE4, 8'h00, 5'b00010);
        run_op("add_7f_01",  OP_ADD, 8'h7F, 8'h01, 1, 8'h80, 8'h00, 5'b01010);
        run_op("sub_borrow", OP_SUB, 8'h01, 8'h02, 1, 8'hFF, 8'h00, 5'b00110);
        run_op("and_zero",   OP_AND, 8'hF0, 8'h0F, 1, 8'h00, 8'h00, 5'b00001);
        run_op("or",         OP_OR,  8'hA0, 8'h05, 1, 8'hA5, 8'h00, 5'b00010);
        run_op("not",        OP_NOT, 8'h0F, 8'h33, 1, 8'hF0, 8'h00, 5'b00010);
        run_op("shl_c",      OP_SHL, 8'h81, 8'h01, 1, 8'h02, 8'h00, 5'b00100);
        run_op("shl_amt0",   OP_SHL, 8'h80, 8'h08, 1, 8'h80, 8'h00, 5'b00010);
        run_op("shr_hibits", OP_SHR, 8'h03, 8'h09, 1, 8'h01, 8'h00, 5'b00100);
        run_op("shr_amt7",   OP_SHR, 8'hC0, 8'h07, 1, 8'h01, 8'h00, 5'b00100);
        run_op("illegal_f",  4'hF,   8'h12, 8'h34, 1, 8'h00, 8'h00, 5'b10001);
        run_op("mul_ff_ff",  OP_MUL, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE, 5'b01100);
        run_op("mul_10_0f",  OP_MUL, 8'h10, 8'h0F, 9, 8'hF0, 8'h00, 5'b00010);
        run_op("mul_by0",    OP_MUL, 8'h12, 8'h00, 9, 8'h00, 8'h00, 5'b00001);
`ifdef ALU_SEQ_DIV_EN
        run_op("div_200_7",  OP_DIV, 8'd200, 8'd7, 9, 8'h1C, 8'h04, 5'b00000);
        run_op("div_ff_01",  OP_DIV, 8'hFF, 8'h01, 9, 8'hFF, 8'h00, 5'b00010);
        run_op("div_by0",    OP_DIV, 8'h55, 8'h00, 1, 8'hFF, 8'h55, 5'b10010);
`else
        run_op("div_200_7",  OP_DIV, 8'd200, 8'd7, 1, 8'h00, 8'h00, 5'b10001);
        run_op("div_by0",    OP_DIV, 8'h55, 8'h00, 1, 8'h00, 8'h00, 5'b10001);
`endif

        // Backpressure: hold the result 5 cycles while a competing request is asserted.
        @(negedge clk);
        bus.op = OP_XOR; bus.a = 8'hF0; bus.b = 8'h3C; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_lo", bus.res_lo, 8'hCC);
        bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h01; bus.in_valid = 1'b1;
        n_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.res_lo !== 8'hCC || bus.res_hi !== 8'h00 ||
                bus.flags !== 5'b00010 || bus.in_ready || bus.busy) n_bad++;
        end
        chk("bp_hold", n_bad, 0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {bus.out_valid, bus.in_ready}, 2'b01);
        @(negedge clk);
        chk("bp_idle_oready", {bus.out_valid, bus.in_ready, bus.res_lo}, {2'b01, 8'hCC});
        bus.out_ready = 1'b0;

        // Reset three cycles into a MUL.
        @(negedge clk);
        bus.op = OP_MUL; bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rm_busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rm_in_ready", bus.in_ready, 1);
        chk("rm_out_valid", bus.out_valid, 0);
        chk("rm_busy_clr", bus.busy, 0);
        chk("rm_res", {bus.res_hi, bus.res_lo}, 16'h0000);
        chk("rm_flags", bus.flags, 5'b00000);
        n_bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) n_bad++;
        end
        chk("rm_no_partial", n_bad, 0);
        run_op("add_after_rst", OP_ADD, 8'h01, 8'h02, 1, 8'h03, 8'h00, 5'b00000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
